fpu_share_arbiter: RTL and testbench

- Shares one FPU (4-bit opcode, two 32-bit operands, vld/rdy operand and result channels, 3-bit error) between two requesters, e.g. the core's FP issue port and a second FP client.
- Round-robin arbitration on the operand channel.
- Records the issuing requester of every accepted operation in an in-order tag FIFO, and routes each FPU result and error back to that requester.
- Sits between the requesters and the FPU; all paths are combinational muxes, and only arbitration and tag state are registered.

---
 rtl/fpu_share_arbiter.sv | 162 ++++++++++++++++
 tb/tb_fpu_share_arbiter.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_share_arbiter.sv
// Two-requester front end for a single in-order FPU: round-robin operand
// arbitration with lock-on-offer, plus an issue-order tag FIFO that steers results.
module fpu_share_arbiter #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  r0_ope,
  input  logic [3:0]  r1_ope,
  input  logic [31:0] r0_in1,
  input  logic [31:0] r0_in2,
  input  logic [31:0] r1_in1,
  input  logic [31:0] r1_in2,
  input  logic        r0_in_vld,
  input  logic        r1_in_vld,
  output logic        r0_in_rdy,
  output logic        r1_in_rdy,
  output logic [31:0] r0_out_data,
  output logic [31:0] r1_out_data,
  output logic [2:0]  r0_out_err,
  output logic [2:0]  r1_out_err,
  output logic        r0_out_vld,
  output logic        r1_out_vld,
  input  logic        r0_out_rdy,
  input  logic        r1_out_rdy,
  output logic [3:0]  f_ope_data,
  output logic [31:0] f_in1_data,
  output logic [31:0] f_in2_data,
  output logic        f_in_vld,
  input  logic        f_in_rdy,
  input  logic [31:0] f_out_data,
  input  logic [2:0]  f_err,
  input  logic        f_out_vld,
  output logic        f_out_rdy,
  output logic        err_orphan
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshakes: a transfer happens on a rising edge where vld && rdy; an
  // offered operand (f_in_vld) is held, and the grant with it, until accepted.
  logic             gnt_q, gnt_d;
  logic             prio_q, prio_d;
  logic             locked_q, locked_d;
  logic [DEPTH-1:0] tag_q, tag_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_orphan_q, err_orphan_d;

  logic full;
  logic empty;
  logic can_issue;
  logic sel;
  logic sel_vld;
  logic head;
  logic push;
  logic pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    full      = (count_q == CNT_W'(DEPTH));
    empty     = (count_q == '0);
    can_issue = !full;
    sel       = prio_q;
    if (locked_q) begin
      sel = gnt_q;
    end else if (r0_in_vld && !r1_in_vld) begin
      sel = 1'b0;
    end else if (r1_in_vld && !r0_in_vld) begin
      sel = 1'b1;
    end
    sel_vld = sel ? r1_in_vld : r0_in_vld;
    head    = tag_q[rd_ptr_q];
  end

  assign f_ope_data = sel ? r1_ope : r0_ope;
  assign f_in1_data = sel ? r1_in1 : r0_in1;
  assign f_in2_data = sel ? r1_in2 : r0_in2;
  assign f_in_vld   = sel_vld && can_issue;
  assign r0_in_rdy  = !sel && f_in_rdy && can_issue;
  assign r1_in_rdy  = sel && f_in_rdy && can_issue;

  assign r0_out_data = f_out_data;
  assign r1_out_data = f_out_data;
  assign r0_out_err  = f_err;
  assign r1_out_err  = f_err;
  // With nothing outstanding the FPU output is drained so a stray result cannot stall it.
  assign r0_out_vld  = !empty && !head && f_out_vld;
  assign r1_out_vld  = !empty && head && f_out_vld;
  assign f_out_rdy   = empty ? 1'b1 : (head ? r1_out_rdy : r0_out_rdy);

  assign push       = f_in_vld && f_in_rdy;
  assign pop        = !empty && f_out_vld && f_out_rdy;
  assign err_orphan = err_orphan_q;

  always_comb begin
    gnt_d        = gnt_q;
    prio_d       = prio_q;
    locked_d     = locked_q;
    tag_d        = tag_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    err_orphan_d = err_orphan_q;

    if (push) begin
      prio_d   = ~sel;
      locked_d = 1'b0;
    end else if (f_in_vld) begin
      locked_d = 1'b1;
      gnt_d    = sel;
    end else if (locked_q && !sel_vld) begin
      locked_d = 1'b0;
    end

    if (push) begin
      tag_d[wr_ptr_q] = sel;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (f_out_vld && empty) begin
      err_orphan_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q        <= 1'b0;
      prio_q       <= 1'b0;
      locked_q     <= 1'b0;
      tag_q        <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      gnt_q        <= gnt_d;
      prio_q       <= prio_d;
      locked_q     <= locked_d;
      tag_q        <= tag_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      err_orphan_q <= err_orphan_d;
    end
  end

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Bench for fpu_share_arbiter: directed operations from two requesters, a
// lookup-table FPU model with 3-cycle latency, and issue/result scoreboards.
module tb_fpu_share_arbiter;

  localparam int NV = 14;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  r0_ope, r1_ope;
  logic [31:0] r0_in1, r0_in2, r1_in1, r1_in2;
  logic        r0_in_vld, r1_in_vld, r0_in_rdy, r1_in_rdy;
  logic [31:0] r0_out_data, r1_out_data;
  logic [2:0]  r0_out_err, r1_out_err;
  logic        r0_out_vld, r1_out_vld, r0_out_rdy, r1_out_rdy;
  logic [3:0]  f_ope_data;
  logic [31:0] f_in1_data, f_in2_data, f_out_data;
  logic        f_in_vld, f_in_rdy, f_out_vld, f_out_rdy;
  logic [2:0]  f_err;
  logic        err_orphan;

  fpu_share_arbiter #(.DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .r0_ope(r0_ope), .r1_ope(r1_ope),
    .r0_in1(r0_in1), .r0_in2(r0_in2), .r1_in1(r1_in1), .r1_in2(r1_in2),
    .r0_in_vld(r0_in_vld), .r1_in_vld(r1_in_vld),
    .r0_in_rdy(r0_in_rdy), .r1_in_rdy(r1_in_rdy),
    .r0_out_data(r0_out_data), .r1_out_data(r1_out_data),
    .r0_out_err(r0_out_err), .r1_out_err(r1_out_err),
    .r0_out_vld(r0_out_vld), .r1_out_vld(r1_out_vld),
    .r0_out_rdy(r0_out_rdy), .r1_out_rdy(r1_out_rdy),
    .f_ope_data(f_ope_data), .f_in1_data(f_in1_data), .f_in2_data(f_in2_data),
    .f_in_vld(f_in_vld), .f_in_rdy(f_in_rdy),
    .f_out_data(f_out_data), .f_err(f_err),
    .f_out_vld(f_out_vld), .f_out_rdy(f_out_rdy),
    .err_orphan(err_orphan)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Directed vectors: requester, opcode, operands, hand-computed FP result and flags.
  logic        t_req [NV];
  logic [3:0]  t_ope [NV];
  logic [31:0] t_in1 [NV];
  logic [31:0] t_in2 [NV];
  logic [31:0] t_res [NV];
  logic [2:0]  t_err [NV];

  logic [4:0] exp_iss_q[$];
  logic [4:0] exp_res_q[$];

  task automatic set_row(input logic [4:0] i, input logic r, input logic [3:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic [2:0] e);
    t_req[i] = r; t_ope[i] = o; t_in1[i] = a; t_in2[i] = b; t_res[i] = res; t_err[i] = e;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- FPU model ----------------
  typedef struct {
    logic [31:0] d;
    logic [2:0]  e;
    int          due;
  } pend_t;

  pend_t       pend_q[$];
  logic        fpu_hold = 1'b0;
  logic        orphan_force = 1'b0;
  logic [31:0] orphan_data = '0;
  logic        head_rdy;
  logic [31:0] head_data;
  logic [2:0]  head_err;
  int          cyc = 0;

  assign f_out_vld  = orphan_force | (head_rdy & ~fpu_hold);
  assign f_out_data = orphan_force ? orphan_data : head_data;
  assign f_err      = orphan_force ? 3'b000 : head_err;

  initial begin
    logic        do_acc, do_pop, was_rst;
    logic [3:0]  a_ope;
    logic [31:0] a_in1, a_in2;
    pend_t       p;
    head_rdy = 1'b0; head_data = '0; head_err = '0;
    forever begin
      @(negedge clk);
      do_acc  = f_in_vld && f_in_rdy;
      do_pop  = f_out_vld && f_out_rdy && !orphan_force;
      was_rst = rst;
      a_ope = f_ope_data; a_in1 = f_in1_data; a_in2 = f_in2_data;
      @(posedge clk);
      #1;
      cyc++;
      if (was_rst) begin
        pend_q.delete();
      end else begin
        if (do_pop && pend_q.size() > 0) void'(pend_q.pop_front());
        if (do_acc) begin
          p.d = 32'hdeadbeef; p.e = 3'b111; p.due = cyc + 2;
          for (int k = 0; k < NV; k++) begin
            if (t_ope[k] == a_ope && t_in1[k] == a_in1 && t_in2[k] == a_in2) begin
              p.d = t_res[k]; p.e = t_err[k];
            end
          end
          pend_q.push_back(p);
        end
      end
      head_rdy = (pend_q.size() > 0) && (pend_q[0].due <= cyc);
      head_data = head_rdy ? pend_q[0].d : 32'h0;
      head_err  = head_rdy ? pend_q[0].e : 3'b000;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [4:0] idx);
    logic ok;
    ok = 1'b0;
    if (t_req[idx]) begin
      r1_ope = t_ope[idx]; r1_in1 = t_in1[idx]; r1_in2 = t_in2[idx]; r1_in_vld = 1'b1;
    end else begin
      r0_ope = t_ope[idx]; r0_in1 = t_in1[idx]; r0_in2 = t_in2[idx]; r0_in_vld = 1'b1;
    end
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = t_req[idx] ? r1_in_rdy : r0_in_rdy;
      @(posedge clk);
      #1;
    end
    if (t_req[idx]) r1_in_vld = 1'b0;
    else r0_in_vld = 1'b0;
    chk("issue_accepted", 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_iss_q.delete();
    exp_res_q.delete();
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_iss_q.size() != 0 || exp_res_q.size() != 0) && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk(name, 32'(exp_iss_q.size() + exp_res_q.size()), 32'd0);
  endtask

  // ---------------- scoreboard monitors ----------------
  logic [4:0] mi, mr;

  always @(negedge clk) begin
    if (!rst) begin
      if (f_in_vld && f_in_rdy) begin
        if (exp_iss_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL iss_unexpected actual ope=%h in1=%h required none", f_ope_data, f_in1_data);
        end else begin
          mi = exp_iss_q.pop_front();
          chk("iss_ope", 32'(f_ope_data), 32'(t_ope[mi]));
          chk("iss_in1", f_in1_data, t_in1[mi]);
          chk("iss_in2", f_in2_data, t_in2[mi]);
          chk("iss_req_rdy", 32'({r1_in_rdy, r0_in_rdy}), t_req[mi] ? 32'd2 : 32'd1);
          exp_res_q.push_back(mi);
        end
      end
      if (r0_out_vld && r1_out_vld) begin
        checks++; errors++;
        $display("FAIL res_both_vld actual=11 required one-hot");
      end
      if (f_out_vld && f_out_rdy && (r0_out_vld || r1_out_vld)) begin
        if (exp_res_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL res_unexpected actual data=%h required none", f_out_data);
        end else begin
          mr = exp_res_q.pop_front();
          chk("res_route", 32'(r1_out_vld), 32'(t_req[mr]));
          chk("res_data", t_req[mr] ? r1_out_data : r0_out_data, t_res[mr]);
          chk("res_err", 32'(t_req[mr] ? r1_out_err : r0_out_err), 32'(t_err[mr]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    set_row(5'd0,  1'b0, 4'd1, 32'h3f800000, 32'h40000000, 32'h40400000, 3'b000);
    set_row(5'd1,  1'b0, 4'd2, 32'h40000000, 32'h40400000, 32'h40c00000, 3'b000);
    set_row(5'd2,  1'b1, 4'd1, 32'h40800000, 32'h3f800000, 32'h40a00000, 3'b000);
    set_row(5'd3,  1'b0, 4'd1, 32'h3f800000, 32'h3f800000, 32'h40000000, 3'b000);
    set_row(5'd4,  1'b1, 4'd3, 32'h40a00000, 32'h3f800000, 32'h40800000, 3'b000);
    set_row(5'd5,  1'b0, 4'd2, 32'h40000000, 32'h40000000, 32'h40800000, 3'b000);
    set_row(5'd6,  1'b1, 4'd1, 32'h40400000, 32'h40400000, 32'h40c00000, 3'b000);
    set_row(5'd7,  1'b0, 4'd2, 32'h3f800000, 32'h40400000, 32'h40400000, 3'b000);
    set_row(5'd8,  1'b0, 4'd2, 32'h40000000, 32'h40800000, 32'h41000000, 3'b000);
    set_row(5'd9,  1'b0, 4'd1, 32'h41000000, 32'h41000000, 32'h41800000, 3'b000);
    set_row(5'd10, 1'b0, 4'd3, 32'h41000000, 32'h40000000, 32'h40c00000, 3'b000);
    set_row(5'd11, 1'b0, 4'd2, 32'h40400000, 32'h40400000, 32'h41100000, 3'b000);
    set_row(5'd12, 1'b1, 4'd4, 32'h3f800000, 32'h00000000, 32'h7f800000, 3'b010);
    set_row(5'd13, 1'b0, 4'd1, 32'h40000000, 32'h40000000, 32'h40800000, 3'b000);

    rst = 1'b1;
    r0_ope = '0; r1_ope = '0; r0_in1 = '0; r0_in2 = '0; r1_in1 = '0; r1_in2 = '0;
    r0_in_vld = 1'b0; r1_in_vld = 1'b0;
    r0_out_rdy = 1'b0; r1_out_rdy = 1'b0;
    f_in_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state: nothing offered, prio 0 selects r0, FIFO empty drains
    @(negedge clk);
    chk("rst_f_in_vld", 32'(f_in_vld), 32'd0);
    chk("rst_r0_in_rdy", 32'(r0_in_rdy), 32'd1);
    chk("rst_r1_in_rdy", 32'(r1_in_rdy), 32'd0);
    chk("rst_f_out_rdy", 32'(f_out_rdy), 32'd1);
    chk("rst_err_orphan", 32'(err_orphan), 32'd0);
    @(posedge clk);
    #1;

    // single requester, 3-cycle FPU latency
    r0_out_rdy = 1'b1; r1_out_rdy = 1'b1;
    exp_iss_q.push_back(5'd0);
    fork issue(5'd0); join_none
    @(negedge clk);
    chk("t1_f_in_vld", 32'(f_in_vld), 32'd1);
    chk("t1_f_in1", f_in1_data, 32'h3f800000);
    @(negedge clk);
    chk("t1_vld_c2", 32'(r0_out_vld), 32'd0);
    @(negedge clk);
    chk("t1_vld_c3", 32'(r0_out_vld), 32'd0);
    @(negedge clk);
    chk("t1_vld_c4", 32'(r0_out_vld), 32'd1);
    chk("t1_data", r0_out_data, 32'h40400000);
    chk("t1_r1_vld", 32'(r1_out_vld), 32'd0);
    @(posedge clk);
    #1;
    r0_out_rdy = 1'b0; r1_out_rdy = 1'b0;
    @(negedge clk);
    chk("t1_empty", 32'(f_out_rdy), 32'd1);
    @(posedge clk);
    #1;
    r0_out_rdy = 1'b1; r1_out_rdy = 1'b1;
    wait_drain("t1_drain");

    // lock: prio now favours r1, but r0's pending offer keeps the grant
    f_in_rdy = 1'b0;
    exp_iss_q.push_back(5'd1);
    exp_iss_q.push_back(5'd2);
    fork issue(5'd1); join_none
    @(negedge clk);
    chk("t3_c1_f_in_vld", 32'(f_in_vld), 32'd1);
    chk("t3_c1_f_in1", f_in1_data, t_in1[1]);
    @(posedge clk);
    #1;
    fork issue(5'd2); join_none
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk);
      chk("t3_locked_f_in1", f_in1_data, t_in1[1]);
      chk("t3_locked_r1_rdy", 32'(r1_in_rdy), 32'd0);
      @(posedge clk);
      #1;
    end
    f_in_rdy = 1'b1;
    @(negedge clk);
    chk("t3_c4_r0_rdy", 32'(r0_in_rdy), 32'd1);
    chk("t3_c4_r1_rdy", 32'(r1_in_rdy), 32'd0);
    @(posedge clk);
    #1;
    wait_drain("t3_drain");

    // both requesters valid from reset: alternate r0, r1, r0, r1
    do_reset();
    exp_iss_q.push_back(5'd3);
    exp_iss_q.push_back(5'd4);
    exp_iss_q.push_back(5'd5);
    exp_iss_q.push_back(5'd6);
    fork
      begin issue(5'd3); issue(5'd5); end
      begin issue(5'd4); issue(5'd6); end
    join
    wait_drain("t2_drain");

    // full FIFO, no bypass on a same-cycle pop
    do_reset();
    fpu_hold = 1'b1;
    for (int i = 7; i <= 11; i++) exp_iss_q.push_back(5'(i));
    fork
      begin
        for (int i = 7; i <= 11; i++) issue(5'(i));
      end
    join_none
    repeat (4) @(negedge clk);
    @(negedge clk);
    chk("t4_full_r0_rdy", 32'(r0_in_rdy), 32'd0);
    chk("t4_full_f_in_vld", 32'(f_in_vld), 32'd0);
    @(posedge clk);
    #1;
    fpu_hold = 1'b0;
    @(negedge clk);
    chk("t4_pop_r0_out_vld", 32'(r0_out_vld), 32'd1);
    chk("t4_nobypass_r0_rdy", 32'(r0_in_rdy), 32'd0);
    chk("t4_nobypass_f_in_vld", 32'(f_in_vld), 32'd0);
    @(posedge clk);
    #1;
    fpu_hold = 1'b1;
    @(negedge clk);
    chk("t4_after_r0_rdy", 32'(r0_in_rdy), 32'd1);
    chk("t4_after_f_in_vld", 32'(f_in_vld), 32'd1);
    @(posedge clk);
    #1;
    fpu_hold = 1'b0;
    wait_drain("t4_drain");

    // head tag r1 stalled by r1_out_rdy=0
    do_reset();
    r1_out_rdy = 1'b0;
    exp_iss_q.push_back(5'd12);
    issue(5'd12);
    begin
      logic seen;
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
        @(negedge clk);
        seen = r1_out_vld;
      end
      chk("t5_r1_out_vld", 32'(seen), 32'd1);
    end
    chk("t5_hold_f_out_rdy", 32'(f_out_rdy), 32'd0);
    chk("t5_r1_out_err", 32'(r1_out_err), 32'd2);
    chk("t5_r0_out_vld", 32'(r0_out_vld), 32'd0);
    @(negedge clk);
    chk("t5_hold2_f_out_rdy", 32'(f_out_rdy), 32'd0);
    chk("t5_hold2_r1_vld", 32'(r1_out_vld), 32'd1);
    chk("t5_hold2_data", r1_out_data, 32'h7f800000);
    @(posedge clk);
    #1;
    r1_out_rdy = 1'b1;
    wait_drain("t5_drain");
    r0_out_rdy = 1'b0; r1_out_rdy = 1'b0;
    @(negedge clk);
    chk("t5_empty", 32'(f_out_rdy), 32'd1);
    chk("t5_r1_vld_after", 32'(r1_out_vld), 32'd0);

    // orphan result with empty FIFO, then reset mid-operation
    @(posedge clk);
    #1;
    orphan_force = 1'b1;
    orphan_data = 32'h12345678;
    @(negedge clk);
    chk("t6_drain_rdy", 32'(f_out_rdy), 32'd1);
    chk("t6_no_out_vld", 32'({r1_out_vld, r0_out_vld}), 32'd0);
    chk("t6_orphan_before", 32'(err_orphan), 32'd0);
    @(posedge clk);
    #1;
    orphan_force = 1'b0;
    @(negedge clk);
    chk("t6_orphan_set", 32'(err_orphan), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t6_orphan_held", 32'(err_orphan), 32'd1);
    @(posedge clk);
    #1;
    fpu_hold = 1'b1;
    exp_iss_q.push_back(5'd13);
    issue(5'd13);
    @(negedge clk);
    chk("t6_busy_f_out_rdy", 32'(f_out_rdy), 32'd0);
    @(posedge clk);
    #1;
    do_reset();
    fpu_hold = 1'b0;
    @(negedge clk);
    chk("t6_rst_orphan", 32'(err_orphan), 32'd0);
    chk("t6_rst_empty", 32'(f_out_rdy), 32'd1);
    chk("t6_rst_f_in_vld", 32'(f_in_vld), 32'd0);
    repeat (6) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
